// File: rtl/dmem_pipe_pkg.sv
// dmem_pipe_pkg -- shared definitions for the dmem_pipe data-memory slice.
//
// Holds the RV32 funct3 load/store size encodings, the controller state
// encoding and two helpers that turn a store request into byte-lane enables
// and lane-replicated write data.
//
// Configuration macro: DMEM_PIPE_CLEAR_EN adds the CLEAR state used by the
// post-reset zero sweep; without it only RUN exists.
package dmem_pipe_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

`ifdef DMEM_PIPE_CLEAR_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
`else
    typedef enum logic {
        ST_RUN = 1'b0
    } state_e;
`endif

    // Byte-lane enables for a store; memop[1:0] selects the size.
    function automatic logic [3:0] store_be(input logic [2:0] memop,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (memop[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes so the byte
    // enables alone decide which lanes land in memory.
    function automatic logic [31:0] store_lanes(input logic [2:0]  memop,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (memop[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_pipe_ram.sv
// dmem_pipe_ram -- DEPTH x 32 single-port RAM with byte write enables.
//
// Ports:
//   clk    in   clock, rising edge
//   en     in   port enable for this cycle
//   we     in   4-bit byte write enable; all-zero with en means a read
//   addr   in   word index
//   wdata  in   write data, one byte per lane
//   rdata  out  registered read data, updated only by a read
//
// No reset: contents and read register are left to whatever the array holds.
module dmem_pipe_ram
    import dmem_pipe_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe -- one-cycle-latency RV32 data memory with byte/half/word access.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   request presented
//   req_ready  out  request can be accepted (RUN state)
//   req_we     in   1 = store, 0 = load
//   req_memop  in   RV32 funct3 size code (b/h/w/bu/hu)
//   req_addr   in   byte address, ADDR_W bits
//   req_wdata  in   right-aligned store data
//   rsp_valid  out  one-cycle response strobe, cycle after acceptance
//   rsp_rdata  out  extended load data; zero for stores, errors and idle
//   rsp_err    out  request rejected (misaligned, out of range, illegal)
//
// Configuration macro: DMEM_PIPE_CLEAR_EN. When defined, the block sweeps
// zeros through every word after reset release (req_ready low meanwhile).
// When undefined it starts in RUN, has no sweep counter, and memory is
// undefined after power-up.
//
// Stores write the RAM on the acceptance edge, so a load accepted on the
// next edge reads the already-updated word without any forwarding path.
module dmem_pipe
    import dmem_pipe_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // Sign- or zero-extend the addressed byte/half of a read word.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  memop,
                                                input logic [1:0]  off);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = word >> {off, 3'b000};
        case (memop)
            MEMOP_B:  ext = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_BU: ext = {24'h000000, shifted[7:0]};
            MEMOP_H:  ext = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_HU: ext = {16'h0000, shifted[15:0]};
            default:  ext = word;
        endcase
        return ext;
    endfunction

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             misalign;
    logic             illegal;
    logic             oor;
    logic             req_err;

    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    // Response-stage registers.
    logic             vld_d, vld_q;
    logic             err_d, err_q;
    logic             we_d, we_q;
    logic [2:0]       memop_d, memop_q;
    logic [1:0]       off_d, off_q;

    assign idx    = req_addr[IDX_W+1:2];
    assign off    = req_addr[1:0];
    assign accept = req_valid & req_ready;

    // Any address bit above the word index means the word is past DEPTH.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign oor = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        misalign = 1'b0;
        illegal  = 1'b0;
        case (req_memop)
            MEMOP_B, MEMOP_BU: misalign = 1'b0;
            MEMOP_H, MEMOP_HU: misalign = off[0];
            MEMOP_W:           misalign = |off;
            default:           illegal  = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores.
        if (req_we && req_memop[2]) begin
            illegal = 1'b1;
        end
    end

    assign req_err = misalign | illegal | oor;

`ifdef DMEM_PIPE_CLEAR_EN
    state_e           state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             ready_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
`else
    assign req_ready = 1'b1;
`endif

    // RAM port: the sweep owns it while clearing, requests otherwise.
    always_comb begin
        ram_en    = accept & ~req_err;
        ram_we    = (accept && !req_err && req_we) ? store_be(req_memop, off) : 4'b0000;
        ram_addr  = idx;
        ram_wdata = store_lanes(req_memop, req_wdata);
`ifdef DMEM_PIPE_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 4'b1111;
            ram_addr  = clr_cnt_q;
            ram_wdata = 32'h0000_0000;
        end
`endif
    end

    dmem_pipe_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign vld_d   = accept;
    assign err_d   = req_err;
    assign we_d    = req_we;
    assign memop_d = req_memop;
    assign off_d   = off;

    // Request -> response stage boundary. Only the valid bit is reset, so a
    // request in flight when reset asserts produces no response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        err_q   <= err_d;
        we_q    <= we_d;
        memop_q <= memop_d;
        off_q   <= off_d;
    end

    assign rsp_valid = vld_q;
    assign rsp_err   = vld_q & err_q;
    assign rsp_rdata = (vld_q && !err_q && !we_q) ? load_extend(ram_rdata, memop_q, off_q)
                                                  : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe -- directed bench for dmem_pipe with DEPTH=16, ADDR_W=32.
// Build with DMEM_PIPE_CLEAR_EN defined to also exercise the zero sweep.
module tb_dmem_pipe;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

`ifdef DMEM_PIPE_CLEAR_EN
    localparam logic [31:0] READY_IN_RST = 32'd0;
`else
    localparam logic [31:0] READY_IN_RST = 32'd1;
`endif

    dmem_pipe #(
        .DEPTH  (16),
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_memop (req_memop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request at the current negedge and sample its response at
    // the next negedge (one cycle after the acceptance edge).
    task automatic op(input string tag, input logic we, input logic [2:0] memop,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata);
        req_valid = 1'b1;
        req_we    = we;
        req_memop = memop;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        chk($sformatf("%s.valid", tag), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("%s.err", tag),   {31'b0, rsp_err},   {31'b0, exp_err});
        chk($sformatf("%s.rdata", tag), rsp_rdata,          exp_rdata);
    endtask

    task automatic idle_chk(input string tag);
        req_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s.valid", tag), {31'b0, rsp_valid}, 32'd0);
        chk($sformatf("%s.rdata", tag), rsp_rdata,          32'd0);
        chk($sformatf("%s.err", tag),   {31'b0, rsp_err},   32'd0);
    endtask

    // Called at the negedge where rstn was released; counts samples with
    // req_ready low, bounded so a stuck sweep cannot hang the run.
    task automatic sweep_len(output int cnt);
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_memop = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst.valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata,          32'd0);
        chk("rst.err",   {31'b0, rsp_err},   32'd0);
        chk("rst.ready", {31'b0, req_ready}, READY_IN_RST);
        rstn = 1'b1;
`ifdef DMEM_PIPE_CLEAR_EN
        sweep_len(n);
        chk("sweep1.len", n, 32'd16);
        for (int i = 0; i < 16; i++) begin
            op($sformatf("zero%0d", i), 1'b0, OP_W, 32'(i * 4), 32'h0, 1'b0, 32'h0);
        end
`endif
        chk("run.ready", {31'b0, req_ready}, 32'd1);

        // Word store then narrow loads
        op("sw10",  1'b1, OP_W, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
        op("lb13",  1'b0, OP_B, 32'h13, 32'h0,         1'b0, 32'h0000_0011);
        op("lh12",  1'b0, OP_H, 32'h12, 32'h0,         1'b0, 32'h0000_1122);
        op("lw10",  1'b0, OP_W, 32'h10, 32'h0,         1'b0, 32'h1122_3344);
        op("lbu10", 1'b0, OP_BU, 32'h10, 32'h0,        1'b0, 32'h0000_0044);

        // Byte/half stores and sign/zero extension
        op("sw20",  1'b1, OP_W,  32'h20, 32'h0,         1'b0, 32'h0);
        op("sb21",  1'b1, OP_B,  32'h21, 32'h0000_00FF, 1'b0, 32'h0);
        op("lb21",  1'b0, OP_B,  32'h21, 32'h0,         1'b0, 32'hFFFF_FFFF);
        op("lbu21", 1'b0, OP_BU, 32'h21, 32'h0,         1'b0, 32'h0000_00FF);
        op("lw20a", 1'b0, OP_W,  32'h20, 32'h0,         1'b0, 32'h0000_FF00);
        op("sh22",  1'b1, OP_H,  32'h22, 32'hDEAD_8001, 1'b0, 32'h0);
        op("lh22",  1'b0, OP_H,  32'h22, 32'h0,         1'b0, 32'hFFFF_8001);
        op("lhu22", 1'b0, OP_HU, 32'h22, 32'h0,         1'b0, 32'h0000_8001);
        op("lw20b", 1'b0, OP_W,  32'h20, 32'h8001_FF00, 1'b0, 32'h8001_FF00);

        // Error cases leave memory untouched
        op("sw00",   1'b1, OP_W,   32'h00, 32'hA5A5_A5A5, 1'b0, 32'h0);
        op("sw02",   1'b1, OP_W,   32'h02, 32'h1234_5678, 1'b1, 32'h0);
        op("lw00",   1'b0, OP_W,   32'h00, 32'h0,         1'b0, 32'hA5A5_A5A5);
        op("lh05",   1'b0, OP_H,   32'h05, 32'h0,         1'b1, 32'h0);
        op("op011",  1'b0, 3'b011, 32'h00, 32'h0,         1'b1, 32'h0);
        op("op110",  1'b0, 3'b110, 32'h00, 32'h0,         1'b1, 32'h0);
        op("sbu00",  1'b1, OP_BU,  32'h00, 32'h0000_0000, 1'b1, 32'h0);
        op("lw00b",  1'b0, OP_W,   32'h00, 32'h0,         1'b0, 32'hA5A5_A5A5);

        // Address range edge for DEPTH=16
        op("lw40",  1'b0, OP_W, 32'h40,        32'h0,         1'b1, 32'h0);
        op("sw3C",  1'b1, OP_W, 32'h3C,        32'hCAFE_F00D, 1'b0, 32'h0);
        op("lw3C",  1'b0, OP_W, 32'h3C,        32'h0,         1'b0, 32'hCAFE_F00D);
        op("swhi",  1'b1, OP_W, 32'h8000_003C, 32'h0,         1'b1, 32'h0);
        op("lw3Cb", 1'b0, OP_W, 32'h3C,        32'h0,         1'b0, 32'hCAFE_F00D);

        // Back-to-back store/load/store/load to one word
        op("b2b.sw1", 1'b1, OP_W, 32'h30, 32'h0000_0001, 1'b0, 32'h0);
        op("b2b.lw1", 1'b0, OP_W, 32'h30, 32'h0,         1'b0, 32'h0000_0001);
        op("b2b.sw2", 1'b1, OP_W, 32'h30, 32'h0000_0002, 1'b0, 32'h0);
        op("b2b.lw2", 1'b0, OP_W, 32'h30, 32'h0,         1'b0, 32'h0000_0002);
        idle_chk("idle");

        // Reset asserted with a load in flight: no response
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_memop = OP_W;
        req_addr  = 32'h10;
        @(posedge clk);
        #2;
        rstn      = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flight.valid", {31'b0, rsp_valid}, 32'd0);
        chk("flight.rdata", rsp_rdata,          32'd0);
        @(negedge clk);
        rstn = 1'b1;
`ifdef DMEM_PIPE_CLEAR_EN
        sweep_len(n);
        chk("sweep2.len", n, 32'd16);
        op("lw10clr", 1'b0, OP_W, 32'h10, 32'h0, 1'b0, 32'h0);

        // Reset in mid-sweep restarts from word 0
        op("sw00m", 1'b1, OP_W, 32'h00, 32'h5555_5555, 1'b0, 32'h0);
        op("sw3Cm", 1'b1, OP_W, 32'h3C, 32'h5555_5555, 1'b0, 32'h0);
        req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sweep_len(n);
        chk("sweep3.len", n, 32'd16);
        op("lw00m", 1'b0, OP_W, 32'h00, 32'h0, 1'b0, 32'h0);
        op("lw3Cm", 1'b0, OP_W, 32'h3C, 32'h0, 1'b0, 32'h0);
`else
        chk("post.ready", {31'b0, req_ready}, 32'd1);
        op("lw10keep", 1'b0, OP_W, 32'h10, 32'h0, 1'b0, 32'h1122_3344);
`endif
        idle_chk("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
